noise_stat_monitor: RTL and testbench

Measurement block for the signed 16-bit Gaussian noise stream produced by the team's LFSR/moving-sum noise generator. It sits downstream of that generator as the sink of its sample stream. It accumulates a window of 2^LOG2N samples, then reports mean, variance and peak magnitude. It is used for on-chip self-check of noise amplitude and bias, and its results are read back over the host interface.

---
 rtl/noise_stat_monitor.sv | 143 ++++++++++++++
 tb/tb_noise_stat_monitor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_stat_monitor.sv
// Windowed statistics over a signed 16-bit sample stream: after 2**LOG2N accepted
// samples, reports floor mean, clamped variance and peak magnitude with a done pulse.
module noise_stat_monitor #(
   parameter int unsigned LOG2N = 10
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        busy,
   output logic        done,
   output logic [15:0] mean,
   output logic [31:0] variance,
   output logic [15:0] peak
);

   localparam int unsigned SW = 16 + LOG2N;
   localparam int unsigned QW = 31 + LOG2N;
   localparam int unsigned CW = LOG2N + 1;
   localparam logic [CW-1:0] LAST = CW'((2 ** LOG2N) - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACC   = 2'd1;
   localparam logic [1:0] CALC1 = 2'd2;
   localparam logic [1:0] CALC2 = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [SW-1:0] sum_q, sum_d;
   logic [QW-1:0] sumsq_q, sumsq_d;
   logic [15:0]   peak_r_q, peak_r_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   mean_r_q, mean_r_d;
   logic [30:0]   msq_r_q, msq_r_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [15:0]   mean_q, mean_d;
   logic [31:0]   var_q, var_d;
   logic [15:0]   peak_q, peak_d;

   logic signed [31:0] in_ext;
   logic signed [31:0] mean_ext;
   logic [31:0]        sq_in;
   logic [31:0]        mean_sq;
   logic [31:0]        msq_ext;
   logic [15:0]        abs_in;

   // 16-bit magnitude is exact: |-32768| = 16'h8000 read as unsigned.
   assign abs_in   = in_data[15] ? (~in_data + 16'd1) : in_data;
   assign in_ext   = {{16{in_data[15]}}, in_data};
   assign sq_in    = in_ext * in_ext;
   assign mean_ext = {{16{mean_r_q[15]}}, mean_r_q};
   assign mean_sq  = mean_ext * mean_ext;
   assign msq_ext  = {1'b0, msq_r_q};

   always_comb begin
      state_d  = state_q;
      sum_d    = sum_q;
      sumsq_d  = sumsq_q;
      peak_r_d = peak_r_q;
      count_d  = count_q;
      mean_r_d = mean_r_q;
      msq_r_d  = msq_r_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      mean_d   = mean_q;
      var_d    = var_q;
      peak_d   = peak_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sum_d    = '0;
               sumsq_d  = '0;
               peak_r_d = '0;
               count_d  = '0;
               busy_d   = 1'b1;
               state_d  = ACC;
            end
         end
         ACC: begin
            if (in_valid) begin
               sum_d   = sum_q + {{LOG2N{in_data[15]}}, in_data};
               sumsq_d = sumsq_q + QW'(sq_in);
               if (abs_in > peak_r_q) peak_r_d = abs_in;
               count_d = count_q + CW'(1);
               if (count_q == LAST) state_d = CALC1;
            end
         end
         CALC1: begin
            // Upper bits of the accumulators are the arithmetic/logical shift by LOG2N.
            mean_r_d = sum_q[SW-1:LOG2N];
            msq_r_d  = sumsq_q[QW-1:LOG2N];
            state_d  = CALC2;
         end
         CALC2: begin
            mean_d  = mean_r_q;
            var_d   = (msq_ext >= mean_sq) ? (msq_ext - mean_sq) : '0;
            peak_d  = peak_r_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q  <= IDLE;
         sum_q    <= '0;
         sumsq_q  <= '0;
         peak_r_q <= '0;
         count_q  <= '0;
         mean_r_q <= '0;
         msq_r_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         mean_q   <= '0;
         var_q    <= '0;
         peak_q   <= '0;
      end else begin
         state_q  <= state_d;
         sum_q    <= sum_d;
         sumsq_q  <= sumsq_d;
         peak_r_q <= peak_r_d;
         count_q  <= count_d;
         mean_r_q <= mean_r_d;
         msq_r_q  <= msq_r_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         mean_q   <= mean_d;
         var_q    <= var_d;
         peak_q   <= peak_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign mean     = mean_q;
   assign variance = var_q;
   assign peak     = peak_q;

endmodule

// File: tb/tb_noise_stat_monitor.sv
// Directed bench for noise_stat_monitor: a LOG2N=4 instance for hand-computed windows
// and a LOG2N=10 instance fed by an LFSR moving-sum noise source with a reference model.
module tb_noise_stat_monitor;

   logic        clk = 1'b0;
   logic        nreset;
   logic        start4, start10;
   logic        in_valid;
   logic [15:0] in_data;

   logic        busy4, done4, busy10, done10;
   logic [15:0] mean4, peak4, mean10, peak10;
   logic [31:0] var4, var10;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   noise_stat_monitor #(.LOG2N(4)) dut4 (
      .clk      (clk),
      .nreset   (nreset),
      .start    (start4),
      .in_valid (in_valid),
      .in_data  (in_data),
      .busy     (busy4),
      .done     (done4),
      .mean     (mean4),
      .variance (var4),
      .peak     (peak4)
   );

   noise_stat_monitor #(.LOG2N(10)) dut10 (
      .clk      (clk),
      .nreset   (nreset),
      .start    (start10),
      .in_valid (in_valid),
      .in_data  (in_data),
      .busy     (busy10),
      .done     (done10),
      .mean     (mean10),
      .variance (var10),
      .peak     (peak10)
   );

   // Runs one 16-sample window on dut4; cyc = cycles from start edge to done (-1 on timeout).
   task automatic run4(input logic [15:0] vals [16], input bit gaps, input int restart_at,
                       output int cyc, output logic busy_t0,
                       output logic [15:0] mid_mean, output logic [15:0] mid_peak);
      int k = 0;
      cyc = -1;
      @(negedge clk);
      start4   = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1 busy_t0 = busy4;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         start4 = (c == restart_at);
         if (k < 16 && (!gaps || (c % 2) == 1)) begin
            in_valid = 1'b1;
            in_data  = vals[k];
            k++;
         end else begin
            in_valid = 1'b0;
            in_data  = 16'h5555;
         end
         @(posedge clk);
         #1;
         if (c == 8) begin
            mid_mean = mean4;
            mid_peak = peak4;
         end
         if (done4) begin
            cyc = c;
            break;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      start4   = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (busy4 !== 1'b0)  begin n_fail++; $display("FAIL rst_busy4 got %b want 0", busy4); end
      n_checks++; if (done4 !== 1'b0)  begin n_fail++; $display("FAIL rst_done4 got %b want 0", done4); end
      n_checks++; if (mean4 !== 16'd0) begin n_fail++; $display("FAIL rst_mean4 got %h want 0", mean4); end
      n_checks++; if (var4 !== 32'd0)  begin n_fail++; $display("FAIL rst_var4 got %h want 0", var4); end
      n_checks++; if (peak4 !== 16'd0) begin n_fail++; $display("FAIL rst_peak4 got %h want 0", peak4); end
      n_checks++; if (busy10 !== 1'b0) begin n_fail++; $display("FAIL rst_busy10 got %b want 0", busy10); end
      n_checks++; if (done10 !== 1'b0) begin n_fail++; $display("FAIL rst_done10 got %b want 0", done10); end
      n_checks++; if (var10 !== 32'd0) begin n_fail++; $display("FAIL rst_var10 got %h want 0", var10); end
   endtask

   task automatic test_constant();
      logic [15:0] v [16];
      int cyc; logic b0; logic [15:0] mm, mp;
      for (int i = 0; i < 16; i++) v[i] = 16'd100;
      run4(v, 1'b0, 0, cyc, b0, mm, mp);
      n_checks++; if (b0 !== 1'b1)      begin n_fail++; $display("FAIL const_busy_t0 got %b want 1", b0); end
      n_checks++; if (cyc != 18)        begin n_fail++; $display("FAIL const_latency got %0d want 18", cyc); end
      n_checks++; if (busy4 !== 1'b0)   begin n_fail++; $display("FAIL const_busy_at_done got %b want 0", busy4); end
      n_checks++; if (mean4 !== 16'd100) begin n_fail++; $display("FAIL const_mean got %0d want 100", mean4); end
      n_checks++; if (var4 !== 32'd0)   begin n_fail++; $display("FAIL const_var got %0d want 0", var4); end
      n_checks++; if (peak4 !== 16'd100) begin n_fail++; $display("FAIL const_peak got %0d want 100", peak4); end
      @(posedge clk); #1;
      n_checks++; if (done4 !== 1'b0)   begin n_fail++; $display("FAIL const_done_width got %b want 0", done4); end
   endtask

   task automatic test_gaps();
      logic [15:0] v [16];
      int cyc; logic b0; logic [15:0] mm, mp;
      for (int i = 0; i < 16; i++) v[i] = (i % 2 == 0) ? 16'd1000 : 16'hFC18;
      run4(v, 1'b1, 0, cyc, b0, mm, mp);
      n_checks++; if (cyc != 33)            begin n_fail++; $display("FAIL gaps_latency got %0d want 33", cyc); end
      n_checks++; if (mean4 !== 16'd0)      begin n_fail++; $display("FAIL gaps_mean got %h want 0", mean4); end
      n_checks++; if (var4 !== 32'd1000000) begin n_fail++; $display("FAIL gaps_var got %0d want 1000000", var4); end
      n_checks++; if (peak4 !== 16'd1000)   begin n_fail++; $display("FAIL gaps_peak got %0d want 1000", peak4); end
   endtask

   task automatic test_floor();
      logic [15:0] v [16];
      int cyc; logic b0; logic [15:0] mm, mp;
      for (int i = 0; i < 16; i++) v[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      run4(v, 1'b0, 0, cyc, b0, mm, mp);
      n_checks++; if (cyc != 18)           begin n_fail++; $display("FAIL floor_latency got %0d want 18", cyc); end
      n_checks++; if (mean4 !== 16'hFFFF)  begin n_fail++; $display("FAIL floor_mean got %h want ffff", mean4); end
      n_checks++; if (var4 !== 32'd0)      begin n_fail++; $display("FAIL floor_var_clamp got %0d want 0", var4); end
      n_checks++; if (peak4 !== 16'd1)     begin n_fail++; $display("FAIL floor_peak got %0d want 1", peak4); end
   endtask

   task automatic test_min_value();
      logic [15:0] v [16];
      int cyc; logic b0; logic [15:0] mm, mp;
      for (int i = 0; i < 16; i++) v[i] = 16'h8000;
      run4(v, 1'b0, 0, cyc, b0, mm, mp);
      n_checks++; if (mean4 !== 16'h8000) begin n_fail++; $display("FAIL min_mean got %h want 8000", mean4); end
      n_checks++; if (var4 !== 32'd0)     begin n_fail++; $display("FAIL min_var got %0d want 0", var4); end
      n_checks++; if (peak4 !== 16'h8000) begin n_fail++; $display("FAIL min_peak got %h want 8000", peak4); end
   endtask

   task automatic test_start_while_busy();
      logic [15:0] v [16];
      int cyc; logic b0; logic [15:0] mm, mp;
      for (int i = 0; i < 16; i++) v[i] = 16'd7;
      run4(v, 1'b0, 5, cyc, b0, mm, mp);
      n_checks++; if (mm !== 16'h8000)  begin n_fail++; $display("FAIL busy_hold_mean got %h want 8000", mm); end
      n_checks++; if (mp !== 16'h8000)  begin n_fail++; $display("FAIL busy_hold_peak got %h want 8000", mp); end
      n_checks++; if (cyc != 18)        begin n_fail++; $display("FAIL busy_restart_latency got %0d want 18", cyc); end
      n_checks++; if (mean4 !== 16'd7)  begin n_fail++; $display("FAIL busy_mean got %0d want 7", mean4); end
      n_checks++; if (peak4 !== 16'd7)  begin n_fail++; $display("FAIL busy_peak got %0d want 7", peak4); end
   endtask

   task automatic test_reset_mid_window();
      int done_seen = 0;
      @(negedge clk);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = 16'd123;
         @(negedge clk);
      end
      nreset = 1'b0;
      #1;
      n_checks++; if (busy4 !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy4); end
      n_checks++; if (mean4 !== 16'd0) begin n_fail++; $display("FAIL midrst_mean got %h want 0", mean4); end
      n_checks++; if (peak4 !== 16'd0) begin n_fail++; $display("FAIL midrst_peak got %h want 0", peak4); end
      n_checks++; if (var4 !== 32'd0)  begin n_fail++; $display("FAIL midrst_var got %h want 0", var4); end
      @(negedge clk);
      @(negedge clk);
      nreset = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (done4) done_seen++;
      end
      n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL midrst_no_done got %0d want 0", done_seen); end
      n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got %b want 0", busy4); end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_fresh_after_reset();
      logic [15:0] v [16];
      int cyc; logic b0; logic [15:0] mm, mp;
      for (int i = 0; i < 16; i++) v[i] = 16'(i * 100);
      run4(v, 1'b0, 0, cyc, b0, mm, mp);
      n_checks++; if (cyc != 18)          begin n_fail++; $display("FAIL fresh_latency got %0d want 18", cyc); end
      n_checks++; if (mean4 !== 16'd750)  begin n_fail++; $display("FAIL fresh_mean got %0d want 750", mean4); end
      n_checks++; if (var4 !== 32'd212500) begin n_fail++; $display("FAIL fresh_var got %0d want 212500", var4); end
      n_checks++; if (peak4 !== 16'd1500) begin n_fail++; $display("FAIL fresh_peak got %0d want 1500", peak4); end
   endtask

   task automatic test_noise();
      logic [15:0] lfsr = 16'hACE1;
      int hist [4] = '{0, 0, 0, 0};
      int s, k = 0, cyc = -1;
      longint msum = 0, msumsq = 0, mmean, mmsq, msq;
      int mpeak = 0;
      logic [31:0] exp_var;
      @(negedge clk);
      start10 = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 1100; c++) begin
         @(negedge clk);
         start10 = 1'b0;
         if (k < 1024) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            hist[k % 4] = int'(lfsr[13:0]) - (lfsr[13] ? 16384 : 0);
            s = hist[0] + hist[1] + hist[2] + hist[3];
            msum   += s;
            msumsq += longint'(s) * longint'(s);
            if ((s < 0 ? -s : s) > mpeak) mpeak = (s < 0 ? -s : s);
            in_valid = 1'b1;
            in_data  = 16'(s);
            k++;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (done10) begin
            cyc = c;
            break;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      mmean = msum >>> 10;
      mmsq  = msumsq >> 10;
      msq   = mmean * mmean;
      exp_var = (mmsq >= msq) ? 32'(mmsq - msq) : 32'd0;
      n_checks++; if (cyc != 1026)            begin n_fail++; $display("FAIL noise_latency got %0d want 1026", cyc); end
      n_checks++; if (mean10 !== 16'(mmean))  begin n_fail++; $display("FAIL noise_mean got %h want %h", mean10, 16'(mmean)); end
      n_checks++; if (var10 !== exp_var)      begin n_fail++; $display("FAIL noise_var got %0d want %0d", var10, exp_var); end
      n_checks++; if (var10 == 32'd0)         begin n_fail++; $display("FAIL noise_var_nonzero got 0 want >0"); end
      n_checks++; if (peak10 !== 16'(mpeak))  begin n_fail++; $display("FAIL noise_peak got %0d want %0d", peak10, mpeak); end
   endtask

   initial begin
      nreset   = 1'b0;
      start4   = 1'b0;
      start10  = 1'b0;
      in_valid = 1'b0;
      in_data  = 16'd0;
      #23;
      test_reset();
      @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
      test_reset();
      test_constant();
      test_gaps();
      test_floor();
      test_min_value();
      test_start_while_busy();
      test_reset_mid_window();
      test_fresh_after_reset();
      test_noise();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
